// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, nibble S-box tables, bit-permutation map and key-schedule helpers.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam int KEY_W  = 80;
  localparam int BLK_W  = 64;

  localparam logic [4:0] LAST_RND  = 5'd31;
  localparam logic [4:0] FIRST_RND = 5'd1;

  // Nibble i of each table lives at bits [4i+3:4i].
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KFWD,
    S_DEC,
    S_DONE
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    return INV_SBOX[{n, 2'b00} +: 4];
  endfunction

  // Forward layer moves bit i to position perm_pos(i); 16 * 4 == 1 mod 63.
  function automatic int perm_pos(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic int inv_perm_pos(input int i);
    return (i == 63) ? 63 : (i * 4) % 63;
  endfunction

  function automatic logic [KEY_W-1:0] upd_key(input logic [KEY_W-1:0] k,
                                               input logic [4:0] i);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] inv_upd_key(input logic [KEY_W-1:0] k,
                                                   input logic [4:0] i);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ i;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational PRESENT decryption round: inverse permutation, inverse S-box layer, round-key add.
module inv_round
  import present_pkg::*;
(
  input  logic [BLK_W-1:0] x,
  input  logic [BLK_W-1:0] rk,
  output logic [BLK_W-1:0] r
);

  logic [BLK_W-1:0] unperm;
  logic [BLK_W-1:0] unsub;

  for (genvar i = 0; i < BLK_W; i++) begin : g_unperm
    localparam int SRC = perm_pos(i);
    assign unperm[i] = x[SRC];
  end

  for (genvar n = 0; n < 16; n++) begin : g_unsub
    assign unsub[4*n +: 4] = inv_sbox(unperm[4*n +: 4]);
  end

  assign r = unsub ^ rk;

endmodule

// File: rtl/present_dec_iter.sv
// Iterative PRESENT-80 decryptor: walks the key schedule forward to K32, then decrypts one round per cycle.
module present_dec_iter
  import present_pkg::*;
#(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ct,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] pt
);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] st_q, st_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] tag_q, tag_d;
  logic [KEY_W-1:0] k32_q, k32_d;
  logic             out_valid_q, out_valid_d;
  logic             cache_vld_q, cache_vld_d;

  logic [KEY_W-1:0] key_fwd;
  logic [KEY_W-1:0] key_inv;
  logic [BLK_W-1:0] round_out;
  logic             cache_hit;

  assign key_fwd   = upd_key(key_q, cnt_q);
  assign key_inv   = inv_upd_key(key_q, cnt_q);
  assign cache_hit = CACHE_KEY && cache_vld_q && (key == tag_q);

  inv_round u_inv_round (
    .x  (st_q),
    .rk (key_inv[KEY_W-1 -: BLK_W]),
    .r  (round_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    pt_d        = pt_q;
    key_d       = key_q;
    tag_d       = tag_q;
    k32_d       = k32_q;
    out_valid_d = out_valid_q;
    cache_vld_d = cache_vld_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (cache_hit) begin
            st_d    = ct ^ k32_q[KEY_W-1 -: BLK_W];
            key_d   = k32_q;
            cnt_d   = LAST_RND;
            state_d = S_DEC;
          end else begin
            // The cached K32 belongs to the old tag until the new schedule completes.
            st_d        = ct;
            key_d       = key;
            tag_d       = key;
            cache_vld_d = 1'b0;
            cnt_d       = FIRST_RND;
            state_d     = S_KFWD;
          end
        end
      end

      S_KFWD: begin
        key_d = key_fwd;
        if (cnt_q == LAST_RND) begin
          st_d        = st_q ^ key_fwd[KEY_W-1 -: BLK_W];
          k32_d       = key_fwd;
          cache_vld_d = 1'b1;
          state_d     = S_DEC;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_DEC: begin
        st_d  = round_out;
        key_d = key_inv;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == FIRST_RND) begin
          pt_d        = round_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      tag_q       <= '0;
      k32_q       <= '0;
      out_valid_q <= 1'b0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      tag_q       <= tag_d;
      k32_q       <= k32_d;
      out_valid_q <= out_valid_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign pt        = pt_q;

endmodule

// File: tb/tb_present_dec_iter.sv
// Self-checking bench for present_dec_iter: known answers, cache, backpressure, reset abort, random blocks.
module tb_present_dec_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] ct = '0;
  logic [79:0] key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] pt;

  int checks = 0;
  int passes = 0;

  logic [79:0] k_zero = '0;
  logic [79:0] k_ones = '1;
  logic [63:0] b_zero = '0;
  logic [63:0] b_ones = '1;

  logic [79:0] key_pool [4];

  present_dec_iter #(.CACHE_KEY(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  always #5 clk = ~clk;

  // Plain forward PRESENT-80 encryption used as the reference.
  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [79:0] k);
    logic [3:0]  sb [16];
    logic [63:0] s, q;
    logic [79:0] kk;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      q = '0;
      for (int b = 0; b < 64; b++) q[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s  = q;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sb[kk[79:76]];
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic send(input logic [79:0] k, input logic [63:0] c);
    int w;
    w = 0;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL send_wait: in_ready got 0 expected 1 within 300 cycles");
    end
    key = k; ct = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key = rnd80(); ct = rnd64();
  endtask

  task automatic wait_out(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) saw_ready = 1'b1;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (pt !== b_zero) $display("[TB] FAIL reset_pt: got %h expected 0", pt); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_kat_zero_key();
    int lat; bit sr;
    send(k_zero, 64'h5579C1387B228445);
    wait_out(lat, sr);
    checks++; if (lat !== 62) $display("[TB] FAIL kat1_latency: got %0d expected 62", lat); else passes++;
    checks++; if (pt !== b_zero) $display("[TB] FAIL kat1_pt: got %h expected %h", pt, b_zero); else passes++;
    take();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL kat1_release: out_valid got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL kat1_idle: in_ready got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_cache_hit();
    int lat; bit sr;
    send(k_zero, 64'hA112FFC72F68417B);
    wait_out(lat, sr);
    checks++; if (lat !== 31) $display("[TB] FAIL hit_latency: got %0d expected 31", lat); else passes++;
    checks++; if (pt !== b_ones) $display("[TB] FAIL hit_pt: got %h expected %h", pt, b_ones); else passes++;
    checks++; if (sr !== 1'b0) $display("[TB] FAIL hit_busy_ready: in_ready seen %b expected 0", sr); else passes++;
    take();
  endtask

  task automatic test_kat_ones_key();
    int lat; bit sr;
    send(k_ones, 64'hE72C46C0F5945049);
    wait_out(lat, sr);
    checks++; if (lat !== 62) $display("[TB] FAIL kat2_latency: got %0d expected 62", lat); else passes++;
    checks++; if (pt !== b_zero) $display("[TB] FAIL kat2_pt: got %h expected %h", pt, b_zero); else passes++;
    take();
  endtask

  task automatic test_backpressure();
    int lat; bit sr; int bad;
    send(k_ones, 64'h3333DCD3213210D2);
    wait_out(lat, sr);
    checks++; if (lat !== 31) $display("[TB] FAIL bp_latency: got %0d expected 31", lat); else passes++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      key = rnd80(); ct = rnd64();
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || pt !== b_ones || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) $display("[TB] FAIL bp_hold: unstable cycles got %0d expected 0 (pt=%h)", bad, pt); else passes++;
    take();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release: out_valid got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; bit sr; int seen;
    send(k_zero, 64'h5579C1387B228445);
    repeat (47) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL abort_in_ready: got %b expected 1", in_ready); else passes++;
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) $display("[TB] FAIL abort_no_output: out_valid cycles got %0d expected 0", seen); else passes++;
    send(k_ones, 64'hE72C46C0F5945049);
    wait_out(lat, sr);
    checks++; if (lat !== 62) $display("[TB] FAIL replay_latency: got %0d expected 62", lat); else passes++;
    checks++; if (pt !== b_zero) $display("[TB] FAIL replay_pt: got %h expected %h", pt, b_zero); else passes++;
    take();
  endtask

  task automatic test_random();
    logic [79:0] last_key;
    logic [79:0] k;
    logic [63:0] p, c;
    int lat, exp_lat, pt_bad, lat_bad;
    bit sr;
    last_key = k_ones;
    pt_bad = 0; lat_bad = 0;
    for (int i = 0; i < 4; i++) key_pool[i] = rnd80();
    for (int v = 0; v < 500; v++) begin
      k = key_pool[$urandom_range(0, 3)];
      p = rnd64();
      c = ref_enc(p, k);
      exp_lat = (k == last_key) ? 31 : 62;
      last_key = k;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      send(k, c);
      wait_out(lat, sr);
      checks++;
      if (pt !== p) begin
        pt_bad++;
        if (pt_bad <= 5) $display("[TB] FAIL rand_pt[%0d]: got %h expected %h", v, pt, p);
      end else passes++;
      checks++;
      if (lat !== exp_lat) begin
        lat_bad++;
        if (lat_bad <= 5) $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", v, lat, exp_lat);
      end else passes++;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] k;
    logic [63:0] p [3];
    logic [63:0] got [$];
    int acc [3];
    int t, lat;
    bit sr, rdy;
    k = key_pool[0];
    send(k, ref_enc(rnd64(), k));
    wait_out(lat, sr);
    take();
    for (int b = 0; b < 3; b++) p[b] = rnd64();
    out_ready = 1'b1;
    t = 0;
    for (int b = 0; b < 3; b++) begin
      key = k; ct = ref_enc(p[b], k); in_valid = 1'b1;
      acc[b] = -1;
      for (int w = 0; w < 100 && acc[b] < 0; w++) begin
        rdy = in_ready;
        @(posedge clk); #1;
        t++;
        if (out_valid) got.push_back(pt);
        if (rdy) acc[b] = t;
      end
    end
    in_valid = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(posedge clk); #1;
      if (out_valid) got.push_back(pt);
    end
    out_ready = 1'b0;
    checks++; if (acc[1] - acc[0] != 33) $display("[TB] FAIL b2b_interval1: got %0d expected 33", acc[1] - acc[0]); else passes++;
    checks++; if (acc[2] - acc[1] != 33) $display("[TB] FAIL b2b_interval2: got %0d expected 33", acc[2] - acc[1]); else passes++;
    checks++; if (got.size() != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", got.size()); else passes++;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (b >= got.size()) $display("[TB] FAIL b2b_pt[%0d]: got none expected %h", b, p[b]);
      else if (got[b] !== p[b]) $display("[TB] FAIL b2b_pt[%0d]: got %h expected %h", b, got[b], p[b]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_kat_zero_key();
    test_cache_hit();
    test_kat_ones_key();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
